// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      tx_data;
    logic               tx_send;
    logic               tx_busy;

    modport master (
        output req_valid,
        output req_data,
        output tx_busy,
        input  req_ready,
        input  tx_data,
        input  tx_send
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  tx_busy,
        output req_ready,
        output tx_data,
        output tx_send
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding frames to a single UART transmitter
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int BUSY_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus,
    output logic [1:0]        grant_id,
    output logic              active,
    output logic              err_nostart
);
    localparam int PW = 2;
    localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   ptr, ptr_next;
    logic [PW-1:0]   grant_next;
    logic [DW-1:0]   data_q, data_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            err_next;
    logic            grant_hit;
    logic [PW-1:0]   grant_idx;
    logic            can_grant;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_hit && bus.req_valid[PW'((int'(ptr) + k) % NREQ)]) begin
                grant_hit = 1'b1;
                grant_idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign can_grant     = (state == IDLE) && !bus.tx_busy && !reset && grant_hit;
    assign bus.req_ready = can_grant ? (NREQ'(1) << grant_idx) : '0;
    assign bus.tx_send   = (state == SEND);
    assign bus.tx_data   = data_q;
    assign active        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            data_q      <= '0;
            cnt         <= '0;
            err_nostart <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            grant_id    <= grant_next;
            data_q      <= data_next;
            cnt         <= cnt_next;
            err_nostart <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        grant_next = grant_id;
        data_next  = data_q;
        cnt_next   = cnt;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (can_grant) begin
                    state_next = SEND;
                    ptr_next   = PW'((int'(grant_idx) + 1) % NREQ);
                    grant_next = grant_idx;
                    data_next  = bus.req_data[int'(grant_idx)*DW +: DW];
                end
            end
            SEND: begin
                state_next = WAIT_HI;
                cnt_next   = '0;
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_LO;
                end else if (cnt == CW'(BUSY_WAIT - 1)) begin
                    // Transmitter never acknowledged the start; drop the frame.
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter NREQ, default 4: number of requesters, fixed at 4 in this revision.
REQ-002 The module SHALL have parameter DW, default 8: frame data width.
REQ-003 The module SHALL have parameter BUSY_WAIT, default 4: maximum cycles to wait for tx_busy to rise after tx_send.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The module SHALL have port req_valid, input, NREQ bits: requester i has a frame pending.
REQ-007 The module SHALL have port req_data, input, NREQ*DW bits: requester i's frame in bits [i*DW +: DW].
REQ-008 The module SHALL have port req_ready, output, NREQ bits: one-hot acceptance strobe.
REQ-009 The module SHALL have port tx_data, output, DW bits: frame driven to the UART transmitter write buffer.
REQ-010 The module SHALL have port tx_send, output, 1 bit: one-cycle start pulse to the UART transmitter.
REQ-011 The module SHALL have port tx_busy, input, 1 bit: the UART transmitter is shifting a frame.
REQ-012 The module SHALL have port grant_id, output, 2 bits: index of the most recently granted requester.
REQ-013 The module SHALL have port active, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The module SHALL have port err_nostart, output, 1 bit: one-cycle pulse when tx_busy fails to rise within BUSY_WAIT.

Function
REQ-015 The state machine SHALL have exactly the states IDLE, SEND, WAIT_HI and WAIT_LO.
REQ-016 Transfer rule: a transfer on requester i SHALL occur in a cycle where req_valid[i]=1 and req_ready[i]=1.
REQ-017 Requester obligation: a requester SHALL hold req_valid and its data stable until its transfer occurs.
REQ-018 req_ready SHALL be combinational and SHALL be nonzero only in IDLE with tx_busy=0; at most one bit SHALL be high.
REQ-019 Arbitration SHALL be round-robin: search from index ptr upward, modulo NREQ; the first i with req_valid[i]=1 is granted.
REQ-020 On a grant of index g: tx_data SHALL take req_data[g] at the clock edge, ptr SHALL become (g+1) mod NREQ, grant_id SHALL become g, and the state SHALL go to SEND.
REQ-021 In SEND, tx_send SHALL be 1 for exactly one cycle; the next state SHALL be WAIT_HI with the wait counter cleared.
REQ-022 WAIT_HI, tx_busy=1: the next state SHALL be WAIT_LO.
REQ-023 WAIT_HI, tx_busy=0: the counter SHALL increment; if the counter reaches BUSY_WAIT-1 with tx_busy still 0, err_nostart SHALL pulse for one cycle and the next state SHALL be IDLE.
REQ-024 WAIT_LO SHALL remain in WAIT_LO while tx_busy=1 and SHALL go to IDLE on the first cycle with tx_busy=0.
REQ-025 Latency: a valid request seen in IDLE SHALL be accepted in cycle N, and tx_send SHALL be high in cycle N+1.
REQ-026 Back-to-back: a new grant SHALL be possible in the first IDLE cycle after WAIT_LO exits; there SHALL be no extra gap cycles.
REQ-027 tx_busy high while in IDLE (transmitter externally busy) SHALL block all grants until tx_busy=0.
REQ-028 No requester SHALL wait more than NREQ-1 other grants while it holds valid.
REQ-029 tx_data SHALL hold its value outside grant edges; tx_data changes only on a grant.
REQ-030 Requests arriving while not in IDLE SHALL be ignored until IDLE, with no loss provided the requester holds valid.

Reset
REQ-031 When reset=1 at a clock edge, the module SHALL set: state=IDLE, ptr=0, grant_id=0, tx_data=0, tx_send=0, err_nostart=0, active=0, wait counter=0.
REQ-032 req_ready SHALL be forced to 0 while reset=1.
REQ-033 Reset mid-frame SHALL abandon the frame without retry; the abandoned frame is not re-issued after reset.
REQ-034 With reset=1 and any req_valid pattern, the module SHALL perform no transfer.

Verification
REQ-035 Single requester: req_valid=4'b0100, req_data[23:16]=8'hAA -> req_ready=4'b0100 in that cycle; tx_send pulse next cycle with tx_data=8'hAA; grant_id=2.
REQ-036 All four valid continuously after reset, data 8'h10/8'h21/8'h32/8'h43 -> tx_data frames in order 8'h10, 8'h21, 8'h32, 8'h43, 8'h10.
REQ-037 tx_busy tied 0 after a grant -> err_nostart pulses exactly once, 1+BUSY_WAIT cycles after tx_send; returns to IDLE; next request is granted normally.
REQ-038 tx_busy held 1 in IDLE with req_valid=4'b0001 -> req_ready stays 0 until tx_busy falls; grant occurs in that same cycle.
REQ-039 reset asserted in WAIT_LO -> all outputs at reset values on the next cycle; after release, with req0 and req3 valid, req0 is granted first (ptr=0).
REQ-040 Bench with a real UART transmitter, baud control 8, frames 8'hF0 and 8'h0F from requesters 1 and 2 -> serial line carries both frames back-to-back; exactly two tx_send pulses.
